// File: rtl/markov_table_arbiter.sv
// Round-robin arbiter sharing the single-port Markov transition-table RAM among
// merge (0), training (1) and note-generator (2) engines, with bounded hold and RMW lock.
module markov_table_arbiter #(
  parameter int AW       = 10,
  parameter int DW       = 16,
  parameter int MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [2:0]      req,
  input  logic [2:0]      lock,
  input  logic [3*AW-1:0] req_addr,
  input  logic [3*DW-1:0] req_wdata,
  input  logic [2:0]      req_we,
  output logic [2:0]      grant,
  output logic            mem_en,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  input  logic [DW-1:0]   mem_rdata,
  output logic [DW-1:0]   rd_data,
  output logic [2:0]      rd_valid
);

  typedef enum logic {IDLE, OWNED} state_t;

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  state_t      state, state_n;
  logic [1:0]  owner, owner_n;
  logic [1:0]  rr_ptr, rr_n;
  logic [7:0]  hold_cnt, hold_n;
  logic [2:0]  grant_n;
  logic [2:0]  others;
  logic        handover;
  logic        own_we;

  function automatic logic [1:0] inc3(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  // First set bit of r searching start, start+1, start+2 (mod 3).
  function automatic logic [1:0] rr_pick(input logic [2:0] r, input logic [1:0] start);
    logic [1:0] c0, c1, c2;
    c0 = start;
    c1 = inc3(c0);
    c2 = inc3(c1);
    if (r[c0])      return c0;
    else if (r[c1]) return c1;
    else            return c2;
  endfunction

  always_comb begin
    state_n  = state;
    owner_n  = owner;
    rr_n     = rr_ptr;
    hold_n   = hold_cnt;
    grant_n  = grant;
    others   = req & ~grant;
    handover = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          owner_n = rr_pick(req, rr_ptr);
          grant_n = 3'b001 << owner_n;
          state_n = OWNED;
          hold_n  = '0;
        end
      end
      OWNED: begin
        handover = !req[owner] ||
                   (!lock[owner] && (hold_cnt == HOLD_LAST) && (|others));
        if (handover) begin
          rr_n   = inc3(owner);
          hold_n = '0;
          if (|others) begin
            // Owner's own bit is masked out, so the search never lands back on it.
            owner_n = rr_pick(others, inc3(owner));
            grant_n = 3'b001 << owner_n;
          end else begin
            state_n = IDLE;
            grant_n = '0;
          end
        end else if (hold_cnt != HOLD_LAST) begin
          hold_n = hold_cnt + 8'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      hold_cnt <= '0;
      grant    <= '0;
      rd_valid <= '0;
    end else begin
      state    <= state_n;
      owner    <= owner_n;
      rr_ptr   <= rr_n;
      hold_cnt <= hold_n;
      grant    <= grant_n;
      rd_valid <= grant & req & ~req_we;
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    own_we    = 1'b0;
    if (|grant) begin
      case (owner)
        2'd0: begin
          mem_addr  = req_addr[0*AW +: AW];
          mem_wdata = req_wdata[0*DW +: DW];
          own_we    = req_we[0];
        end
        2'd1: begin
          mem_addr  = req_addr[1*AW +: AW];
          mem_wdata = req_wdata[1*DW +: DW];
          own_we    = req_we[1];
        end
        2'd2: begin
          mem_addr  = req_addr[2*AW +: AW];
          mem_wdata = req_wdata[2*DW +: DW];
          own_we    = req_we[2];
        end
        default: begin
          mem_addr  = '0;
          mem_wdata = '0;
          own_we    = 1'b0;
        end
      endcase
    end
  end

  assign mem_en  = |(grant & req);
  assign mem_we  = mem_en & own_we;
  assign rd_data = mem_rdata;

endmodule

// File: tb/tb_markov_table_arbiter.sv
// Directed bench for markov_table_arbiter: two instances share stimulus,
// one with MAX_HOLD=4 (short preemption) and one with MAX_HOLD=16.
module tb_markov_table_arbiter;
  localparam int AW = 10;
  localparam int DW = 16;

  logic            clk;
  logic            reset;
  logic [2:0]      req;
  logic [2:0]      lock;
  logic [3*AW-1:0] req_addr;
  logic [3*DW-1:0] req_wdata;
  logic [2:0]      req_we;
  logic [DW-1:0]   mem_rdata;

  logic [2:0]      grant, rd_valid;
  logic            mem_en, mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata, rd_data;

  logic [2:0]      grant_b, rd_valid_b;
  logic            mem_en_b, mem_we_b;
  logic [AW-1:0]   mem_addr_b;
  logic [DW-1:0]   mem_wdata_b, rd_data_b;

  int n_cmp = 0;
  int n_bad = 0;

  markov_table_arbiter #(.AW(AW), .DW(DW), .MAX_HOLD(4)) dut (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_we(req_we), .grant(grant), .mem_en(mem_en),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  markov_table_arbiter #(.AW(AW), .DW(DW), .MAX_HOLD(16)) dut16 (
    .clk(clk), .reset(reset), .req(req), .lock(lock), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_we(req_we), .grant(grant_b), .mem_en(mem_en_b),
    .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .mem_rdata(mem_rdata), .rd_data(rd_data_b), .rd_valid(rd_valid_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    lock  = '0;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    req       = '0;
    lock      = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_we    = '0;
    mem_rdata = 16'h0000;

    // Reset and single read
    tick();
    tick();
    check("rst_grant",    32'(grant),    32'h0);
    check("rst_rd_valid", 32'(rd_valid), 32'h0);
    check("rst_mem_en",   32'(mem_en),   32'h0);
    check("rst_mem_we",   32'(mem_we),   32'h0);
    reset = 1'b0;
    req   = 3'b010;
    req_addr[1*AW +: AW] = 10'h005;
    tick();
    check("rd1_grant",    32'(grant),    32'h2);
    check("rd1_mem_en",   32'(mem_en),   32'h1);
    check("rd1_mem_addr", 32'(mem_addr), 32'h005);
    check("rd1_mem_we",   32'(mem_we),   32'h0);
    check("rd1_rv_early", 32'(rd_valid), 32'h0);
    mem_rdata = 16'h1234;
    tick();
    check("rd1_rd_valid", 32'(rd_valid), 32'h2);
    check("rd1_rd_data",  32'(rd_data),  32'h1234);
    req = 3'b000;
    tick();
    check("rd1_release",  32'(grant),    32'h0);
    check("rd1_rv_done",  32'(rd_valid), 32'h0);
    check("rd1_en_idle",  32'(mem_en),   32'h0);

    // Round-robin with MAX_HOLD=4, no idle bubble between owners
    do_reset();
    req = 3'b111;
    for (int k = 0; k < 13; k++) begin
      tick();
      check($sformatf("rr_grant_%0d", k), 32'(grant), 32'(3'b001 << ((k / 4) % 3)));
      check($sformatf("rr_en_%0d", k), 32'(mem_en), 32'h1);
    end
    req = 3'b000;
    tick();

    // Release with handover and pointer order
    do_reset();
    req = 3'b101;
    tick();
    check("ho_first",   32'(grant), 32'h1);
    req = 3'b100;
    tick();
    check("ho_to_2",    32'(grant), 32'h4);
    req = 3'b011;
    tick();
    check("ho_2_to_0",  32'(grant), 32'h1);
    req = 3'b110;
    tick();
    check("ho_0_to_1",  32'(grant), 32'h2);
    req = 3'b000;
    tick();
    check("ho_idle",    32'(grant), 32'h0);
    req = 3'b011;
    tick();
    check("ho_ptr2_pick0", 32'(grant), 32'h1);
    req = 3'b000;
    tick();
    req = 3'b101;
    tick();
    check("ho_ptr1_pick2", 32'(grant), 32'h4);
    req = 3'b000;
    tick();

    // Lock blocks preemption (MAX_HOLD=16 instance)
    do_reset();
    req  = 3'b011;
    lock = 3'b001;
    tick();
    check("lk_grant_0", 32'(grant_b), 32'h1);
    for (int k = 1; k < 30; k++) begin
      tick();
      check($sformatf("lk_grant_%0d", k), 32'(grant_b), 32'h1);
    end
    lock = 3'b000;
    tick();
    check("lk_unlock", 32'(grant_b), 32'h2);
    req = 3'b000;
    tick();

    // Locked read-modify-write by requester 1
    do_reset();
    req    = 3'b010;
    lock   = 3'b010;
    req_we = 3'b000;
    req_addr[1*AW +: AW] = 10'h020;
    tick();
    check("rmw_grant",    32'(grant),    32'h2);
    check("rmw_rd_addr",  32'(mem_addr), 32'h020);
    check("rmw_rd_we",    32'(mem_we),   32'h0);
    req = 3'b011;
    mem_rdata = 16'h0006;
    tick();
    check("rmw_rd_valid", 32'(rd_valid), 32'h2);
    check("rmw_rd_data",  32'(rd_data),  32'h0006);
    req_we = 3'b010;
    req_wdata[1*DW +: DW] = 16'h0007;
    #1;
    check("rmw_mem_we",    32'(mem_we),    32'h1);
    check("rmw_mem_wdata", 32'(mem_wdata), 32'h0007);
    check("rmw_wr_addr",   32'(mem_addr),  32'h020);
    for (int k = 0; k < 6; k++) begin
      tick();
      check($sformatf("rmw_hold_%0d", k), 32'(grant), 32'h2);
      check($sformatf("rmw_norv_%0d", k), 32'(rd_valid), 32'h0);
    end
    lock   = 3'b000;
    req    = 3'b001;
    req_we = 3'b000;
    tick();
    check("rmw_to_0", 32'(grant), 32'h1);
    req = 3'b000;
    tick();

    // Reset during an owner-2 read
    do_reset();
    req = 3'b100;
    req_addr[2*AW +: AW] = 10'h3a5;
    tick();
    check("mr_grant2", 32'(grant),    32'h4);
    check("mr_addr",   32'(mem_addr), 32'h3a5);
    reset = 1'b1;
    tick();
    check("mr_grant0", 32'(grant),    32'h0);
    check("mr_rv0",    32'(rd_valid), 32'h0);
    reset = 1'b0;
    req   = 3'b001;
    tick();
    check("mr_regrant", 32'(grant),    32'h1);
    check("mr_rv_none", 32'(rd_valid), 32'h0);
    tick();
    check("mr_rv_new",  32'(rd_valid), 32'h1);
    req = 3'b000;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
